// File: rtl/dsp_pkg.sv
// Shared DSP definitions: mode encodings and the packed FIFO entry layout.
package dsp_pkg;

  localparam logic [1:0] MODE_FIR  = 2'd0;
  localparam logic [1:0] MODE_IIR  = 2'd1;
  localparam logic [1:0] MODE_FFT  = 2'd2;
  localparam logic [1:0] MODE_IDLE = 2'd3;

  localparam int unsigned DataWidth = 16;

  // Field names avoid the 'real' keyword.
  typedef struct packed {
    logic                 last;
    logic [DataWidth-1:0] im;
    logic [DataWidth-1:0] re;
  } dsp_entry_t;

  function automatic int unsigned entry_width(int unsigned dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/dsp_out_buffer_if.sv
// Handshake bundle between the DSP source, the output buffer and the host/DMA consumer.
interface dsp_out_buffer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
);
  logic [1:0]              mode;
  logic [DATA_WIDTH-1:0]   in_real;
  logic [DATA_WIDTH-1:0]   in_imag;
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   out_real;
  logic [DATA_WIDTH-1:0]   out_imag;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic                    clr_overflow;
  logic [15:0]             drop_count;

  modport master (
    output mode, in_real, in_imag, in_valid, out_ready, clr_overflow,
    input  out_real, out_imag, out_last, out_valid, level, overflow, drop_count
  );

  modport slave (
    input  mode, in_real, in_imag, in_valid, out_ready, clr_overflow,
    output out_real, out_imag, out_last, out_valid, level, overflow, drop_count
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: Depth x Width registers, one write port, asynchronous read, no reset.
module sync_fifo_mem #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Width-1:0]         i_wdata,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dsp_out_buffer.sv
// FWFT output buffer for the DSP stream with FFT frame tagging and sticky overflow.
// Optional drop counter enabled by defining DSP_OUTBUF_STATS_EN.
module dsp_out_buffer
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FRAME_LEN  = 8
) (
  input logic            clk,
  input logic            rst,
  dsp_out_buffer_if.slave bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;
  localparam int unsigned FrameW = $clog2(FRAME_LEN);
  localparam int unsigned EntryW = 2 * DATA_WIDTH + 1;

  localparam logic [LvlW-1:0]   LvlFull   = LvlW'(DEPTH);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAME_LEN - 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] im;
    logic [DATA_WIDTH-1:0] re;
  } entry_t;

  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [LvlW-1:0]   r_level;
  logic [FrameW-1:0] r_frame_cnt;
  logic [1:0]        r_mode_prev;
  logic              r_overflow;

  logic              w_full, w_valid, w_active, w_pop, w_push, w_drop, w_is_fft;
  logic [FrameW-1:0] w_frame_cur;
  entry_t            w_wr_entry, w_rd_entry;
  logic [EntryW-1:0] w_rdata;

  assign w_full   = (r_level == LvlFull);
  assign w_valid  = (r_level != '0);
  assign w_active = bus.in_valid && (bus.mode != MODE_IDLE);
  assign w_pop    = w_valid && bus.out_ready;
  assign w_push   = w_active && (!w_full || w_pop);
  assign w_drop   = w_active && w_full && !w_pop;
  assign w_is_fft = (bus.mode == MODE_FFT);

  // A mode change restarts framing so this cycle's sample is index 0.
  assign w_frame_cur = (bus.mode != r_mode_prev) ? '0 : r_frame_cnt;

  assign w_wr_entry.last = w_is_fft && (w_frame_cur == FrameLast);
  assign w_wr_entry.im   = bus.in_imag;
  assign w_wr_entry.re   = bus.in_real;

  sync_fifo_mem #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign w_rd_entry = entry_t'(w_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_frame_cnt <= '0;
      r_mode_prev <= MODE_FIR;
      r_overflow  <= 1'b0;
    end else begin
      r_mode_prev <= bus.mode;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // Dropped FFT samples still advance the counter to keep frame alignment.
      if (!w_is_fft)         r_frame_cnt <= '0;
      else if (bus.in_valid) r_frame_cnt <= w_frame_cur + 1'b1;
      else                   r_frame_cnt <= w_frame_cur;
      if (w_drop)                r_overflow <= 1'b1;
      else if (bus.clr_overflow) r_overflow <= 1'b0;
    end
  end

`ifdef DSP_OUTBUF_STATS_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (bus.clr_overflow) begin
      r_drop_count <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign bus.drop_count = r_drop_count;
`else
  assign bus.drop_count = 16'd0;
`endif

  assign bus.out_valid = w_valid;
  assign bus.out_real  = w_valid ? w_rd_entry.re : '0;
  assign bus.out_imag  = w_valid ? w_rd_entry.im : '0;
  assign bus.out_last  = w_valid ? w_rd_entry.last : 1'b0;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_dsp_out_buffer.sv
// Directed self-checking bench for dsp_out_buffer (DEPTH=16, FRAME_LEN=8).
module tb_dsp_out_buffer;

`ifdef DSP_OUTBUF_STATS_EN
  localparam int unsigned Stats = 1;
`else
  localparam int unsigned Stats = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dsp_out_buffer_if #(.DATA_WIDTH(16), .DEPTH(16)) bus ();

  dsp_out_buffer #(
    .DATA_WIDTH (16),
    .DEPTH      (16),
    .FRAME_LEN  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] re, input logic [15:0] im);
    bus.in_valid = v;
    bus.in_real  = re;
    bus.in_imag  = im;
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = 2'd0;
    bus.out_ready = 1'b0;
    bus.clr_overflow = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    tick();
    tick();
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_level", 32'(bus.level), 32'd0);
    chk("reset_ovf", 32'(bus.overflow), 32'd0);
    chk("reset_drop", 32'(bus.drop_count), 32'd0);
    chk("reset_real", 32'(bus.out_real), 32'd0);
    chk("reset_last", 32'(bus.out_last), 32'd0);

    // Pass-through, FIR mode, consumer always ready.
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), 16'h0);
      tick();
      chk("pt_valid", 32'(bus.out_valid), 32'd1);
      chk("pt_real", 32'(bus.out_real), 32'(i));
      chk("pt_last", 32'(bus.out_last), 32'd0);
      chk("pt_level", 32'(bus.level), 32'd1);
    end
    drive(1'b0, 16'h0, 16'h0);
    tick();
    chk("pt_drained", 32'(bus.out_valid), 32'd0);

    // FFT framing: last on samples 8 and 16.
    bus.mode = 2'd2;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(100 + i), 16'(i));
      tick();
      chk("fft_real", 32'(bus.out_real), 32'(100 + i));
      chk("fft_imag", 32'(bus.out_imag), 32'(i));
      chk("fft_last", 32'(bus.out_last), 32'((i == 8) || (i == 16)));
    end
    drive(1'b0, 16'h0, 16'h0);
    tick();

    // Three samples, detour through FIR, back to FFT: framing restarts.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 16'(150 + i), 16'h0);
      tick();
      chk("fft_pre_last", 32'(bus.out_last), 32'd0);
    end
    drive(1'b0, 16'h0, 16'h0);
    bus.mode = 2'd0;
    tick();
    bus.mode = 2'd2;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(160 + i), 16'h0);
      tick();
      chk("fft_restart_last", 32'(bus.out_last), 32'(i == 8));
    end
    drive(1'b0, 16'h0, 16'h0);
    tick();
    chk("fft_drained", 32'(bus.level), 32'd0);

    // Fill with consumer stalled, then overflow by two.
    bus.mode = 2'd0;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      drive(1'b1, 16'(16'h200 + i), 16'h0);
      tick();
      if (i == 16) begin
        chk("fill_level16", 32'(bus.level), 32'd16);
        chk("fill_no_ovf", 32'(bus.overflow), 32'd0);
      end
      if (i == 17) chk("fill_ovf17", 32'(bus.overflow), 32'd1);
    end
    chk("ovf_level", 32'(bus.level), 32'd16);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_drop", 32'(bus.drop_count), 32'(2 * Stats));
    chk("ovf_head", 32'(bus.out_real), 32'h201);

    // Push and pop together while full: no drop, head advances.
    bus.out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      drive(1'b1, 16'(16'h300 + j), 16'h0);
      tick();
      chk("pp_level", 32'(bus.level), 32'd16);
      chk("pp_head", 32'(bus.out_real), 32'(16'h201 + j));
      chk("pp_ovf", 32'(bus.overflow), 32'd1);
      chk("pp_drop", 32'(bus.drop_count), 32'(2 * Stats));
    end

    // Clear racing a drop: drop wins.
    bus.out_ready = 1'b0;
    bus.clr_overflow = 1'b1;
    drive(1'b1, 16'h3FF, 16'h0);
    tick();
    chk("race_ovf", 32'(bus.overflow), 32'd1);
    chk("race_drop", 32'(bus.drop_count), 32'(Stats));
    drive(1'b0, 16'h0, 16'h0);
    tick();
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    chk("clr_drop", 32'(bus.drop_count), 32'd0);
    bus.clr_overflow = 1'b0;

    // Drain six to leave ten buffered, then reset mid-stream.
    bus.out_ready = 1'b1;
    repeat (6) tick();
    chk("mid_level", 32'(bus.level), 32'd10);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_real", 32'(bus.out_real), 32'd0);
    drive(1'b1, 16'h04AA, 16'hFFFB);
    tick();
    chk("post_valid", 32'(bus.out_valid), 32'd1);
    chk("post_real", 32'(bus.out_real), 32'h04AA);
    chk("post_imag", 32'(bus.out_imag), 32'hFFFB);
    chk("post_level", 32'(bus.level), 32'd1);

    // Idle mode ignores input.
    bus.mode = 2'd3;
    drive(1'b1, 16'h0555, 16'h0);
    tick();
    chk("idle_level", 32'(bus.level), 32'd1);
    chk("idle_head", 32'(bus.out_real), 32'h04AA);
    drive(1'b0, 16'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
